meta_arbiter: RTL and testbench
===============================

META_ARBITER -- requirements
Module: meta_arbiter

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of requesting metadata channels (2..16).
REQ-002 SHALL have parameter META_WIDTH, default 2: width of one metadata item in bits.
REQ-003 SHALL have parameter MAX_BURST, default 4: maximum consecutive grants to one channel (1..255).
REQ-004 SHALL have port CLK  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port RESET_N  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port RX_DATA  in  CHANNELS*META_WIDTH  per-channel item; channel i occupies bits [(i+1)*META_WIDTH-1 : i*META_WIDTH].
REQ-007 SHALL have port RX_SRC_RDY  in  CHANNELS  per-channel item valid.
REQ-008 SHALL have port RX_DST_RDY  out  CHANNELS  per-channel item accepted.
REQ-009 SHALL have port TX_DATA  out  META_WIDTH  granted item.
REQ-010 SHALL have port TX_CHAN  out  log2(CHANNELS)  index of the source channel of TX_DATA.
REQ-011 SHALL have port TX_SRC_RDY  out  1  TX_DATA/TX_CHAN valid.
REQ-012 SHALL have port TX_DST_RDY  in  1  downstream accepts.

Function
REQ-013 SHALL treat a transfer as complete on any cycle where SRC_RDY and DST_RDY are both high, on RX and TX alike.
REQ-014 SHALL hold one output register; register is "free" when TX_SRC_RDY=0 or TX_DST_RDY=1.
REQ-015 SHALL, when free, select at most one requesting channel per cycle and drive RX_DST_RDY high only for that channel; all other RX_DST_RDY bits low.
REQ-016 SHALL assert RX_DST_RDY combinationally from RX_SRC_RDY, TX_DST_RDY and internal state, with no combinational path from RX_DATA.
REQ-017 SHALL present the accepted item on TX_DATA/TX_CHAN with TX_SRC_RDY=1 exactly one cycle after acceptance (latency 1); full throughput of one item per cycle.
REQ-018 SHALL keep TX_DATA, TX_CHAN, TX_SRC_RDY stable while TX_SRC_RDY=1 and TX_DST_RDY=0.
REQ-019 SHALL implement FSM with states IDLE (no lock) and LOCK (channel L locked, burst counter B = grants taken by L).
REQ-020 SHALL, in IDLE when free, grant the first requesting channel searching round-robin from (last_grant+1) mod CHANNELS, go to LOCK with L=grant, B=1; stay IDLE if none request.
REQ-021 SHALL, in LOCK when free, re-grant L if RX_SRC_RDY[L]=1 and B<MAX_BURST (B increments); otherwise grant round-robin from L+1 excluding L, starting a new lock with B=1, or go IDLE if no other channel requests.
REQ-022 SHALL, with MAX_BURST=1, degenerate to pure per-item round-robin.
REQ-023 SHALL not advance FSM, B or last_grant on cycles where the register is not free.
REQ-024 SHALL size B as 8 bits; B never exceeds MAX_BURST, no wrap.
REQ-025 SHALL handle simultaneous TX output and RX acceptance in one cycle without bubble or loss.

Reset
REQ-026 SHALL, on RESET_N low, asynchronously clear TX_SRC_RDY to 0, TX_DATA and TX_CHAN to 0, FSM to IDLE, B to 0, last_grant to CHANNELS-1 (so channel 0 has first priority).
REQ-027 SHALL drive RX_DST_RDY all-zero while RESET_N is low; an item held in the output register at reset assertion is discarded.

Configuration
REQ-028 SHALL, with macro META_ARBITER_STATS_EN defined, add output STAT_GRANTS (CHANNELS*32) holding per-channel saturating counts of completed RX transfers, cleared by reset and input STAT_CLR (1, synchronous clear; clear wins over a simultaneous increment).
REQ-029 SHALL, without META_ARBITER_STATS_EN, omit STAT_GRANTS, STAT_CLR and the counters; arbitration behaviour identical.

Structure
REQ-030 SHALL place the FSM state enum type and the burst counter width constant (8) in shared package meta_arbiter_pkg; log2 from math_pkg.
REQ-031 SHALL implement the round-robin search as sub-module rr_select (combinational: request vector, start index, exclude mask -> one-hot grant plus found flag).

Verification
REQ-032 SHALL verify: after reset, all 4 channels request continuously, TX_DST_RDY=1, MAX_BURST=4 -> TX_CHAN sequence 0,0,0,0,1,1,1,1,2,... one item per cycle.
REQ-033 SHALL verify: only channel 2 requests, 10 items -> all 10 granted back-to-back, TX_CHAN=2, lock restarts at B=1 after each 4.
REQ-034 SHALL verify: TX_DST_RDY low 5 cycles with item from channel 1 pending -> TX outputs stable, RX_DST_RDY all 0, B and FSM frozen.
REQ-035 SHALL verify: MAX_BURST=1, channels 1 and 3 request -> TX_CHAN alternates 1,3,1,3.
REQ-036 SHALL verify: RESET_N pulled low while TX_SRC_RDY=1 -> TX_SRC_RDY=0 immediately, first grant after release is lowest requesting channel from 0.
REQ-037 SHALL verify with META_ARBITER_STATS_EN: 2000 random transfers with random backpressure -> sum of STAT_GRANTS equals 2000 and per-channel counts match scoreboard.

Source files
------------

// File: rtl/math_pkg.sv
// Small math helpers shared across the codebase.
package math_pkg;

   // Ceiling log2, never less than 1 so a 2-entry index still has a bit.
   function automatic int log2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/meta_arbiter_pkg.sv
// Shared types and constants for the metadata arbiter.
package meta_arbiter_pkg;

   typedef enum logic {IDLE, LOCK} arb_state_t;

   localparam int BURST_W = 8;

endpackage

// File: rtl/meta_arbiter_rr_select.sv
// Combinational round-robin picker: first eligible request at or after 'start', wrapping.
module rr_select
   import math_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]       req,
   input  logic [log2(N)-1:0] start,
   input  logic [N-1:0]       exclude,
   output logic [N-1:0]       grant,
   output logic               found
);

   logic [N-1:0] eligible;

   assign eligible = req & ~exclude;

   // Two passes: from start up to N-1, then the wrapped range below start.
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int j = 0; j < N; j++) begin
         if (!found && j >= int'(start) && eligible[j]) begin
            grant[j] = 1'b1;
            found    = 1'b1;
         end
      end
      for (int j = 0; j < N; j++) begin
         if (!found && j < int'(start) && eligible[j]) begin
            grant[j] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/meta_arbiter.sv
// Burst-limited round-robin arbiter merging per-channel metadata into one registered stream.
// Optional per-channel grant statistics are enabled by defining META_ARBITER_STATS_EN.
module meta_arbiter
   import math_pkg::*;
   import meta_arbiter_pkg::*;
#(
   parameter int CHANNELS   = 4,
   parameter int META_WIDTH = 2,
   parameter int MAX_BURST  = 4
) (
   input  logic                           CLK,
   input  logic                           RESET_N,
   input  logic [CHANNELS*META_WIDTH-1:0] RX_DATA,
   input  logic [CHANNELS-1:0]            RX_SRC_RDY,
   output logic [CHANNELS-1:0]            RX_DST_RDY,
   output logic [META_WIDTH-1:0]          TX_DATA,
   output logic [log2(CHANNELS)-1:0]      TX_CHAN,
   output logic                           TX_SRC_RDY,
   input  logic                           TX_DST_RDY
`ifdef META_ARBITER_STATS_EN
   ,
   input  logic                           STAT_CLR,
   output logic [CHANNELS*32-1:0]         STAT_GRANTS
`endif
);

   localparam int CW = log2(CHANNELS);

   arb_state_t            state;
   logic [CW-1:0]         lock_chan;
   logic [CW-1:0]         last_grant;
   logic [BURST_W-1:0]    burst;

   logic                  free;
   logic [CW-1:0]         rr_start;
   logic [CHANNELS-1:0]   lock_onehot;
   logic [CHANNELS-1:0]   lock_mask;
   logic [CHANNELS-1:0]   rr_grant;
   logic                  rr_found;
   logic                  lock_req;
   logic                  burst_room;
   logic                  use_lock;
   logic [CHANNELS-1:0]   grant;
   logic [CW-1:0]         grant_idx;
   logic [META_WIDTH-1:0] grant_data;
   logic                  accept;

   assign free        = !TX_SRC_RDY || TX_DST_RDY;
   assign rr_start    = (last_grant == CW'(CHANNELS - 1)) ? '0 : last_grant + 1'b1;
   assign lock_onehot = CHANNELS'(1) << lock_chan;
   assign lock_mask   = (state == LOCK) ? lock_onehot : '0;
   assign lock_req    = (state == LOCK) && RX_SRC_RDY[lock_chan];
   assign burst_room  = burst < BURST_W'(MAX_BURST);

   rr_select #(.N(CHANNELS)) u_rr (
      .req     (RX_SRC_RDY),
      .start   (rr_start),
      .exclude (lock_mask),
      .grant   (rr_grant),
      .found   (rr_found)
   );

   // An exhausted lock yields to any other requester; if nobody else wants the
   // bus, the locked channel keeps streaming under a fresh burst instead of idling.
   assign use_lock = lock_req && (burst_room || !rr_found);

   always_comb begin
      grant = '0;
      if (RESET_N && free) begin
         if (use_lock)
            grant = lock_onehot;
         else if (rr_found)
            grant = rr_grant;
      end
   end

   assign RX_DST_RDY = grant;
   assign accept     = |grant;

   always_comb begin
      grant_idx  = '0;
      grant_data = '0;
      for (int j = 0; j < CHANNELS; j++) begin
         if (grant[j]) begin
            grant_idx  = CW'(j);
            grant_data = RX_DATA[j*META_WIDTH +: META_WIDTH];
         end
      end
   end

   // Arbitration state and the output register only move when the register is free.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state      <= IDLE;
         lock_chan  <= '0;
         last_grant <= CW'(CHANNELS - 1);
         burst      <= '0;
         TX_SRC_RDY <= 1'b0;
         TX_DATA    <= '0;
         TX_CHAN    <= '0;
      end else if (free) begin
         TX_SRC_RDY <= accept;
         if (accept) begin
            TX_DATA    <= grant_data;
            TX_CHAN    <= grant_idx;
            state      <= LOCK;
            lock_chan  <= grant_idx;
            last_grant <= grant_idx;
            burst      <= (use_lock && burst_room) ? burst + 1'b1 : BURST_W'(1);
         end else begin
            state <= IDLE;
            burst <= '0;
         end
      end
   end

`ifdef META_ARBITER_STATS_EN
   for (genvar j = 0; j < CHANNELS; j++) begin : g_stat
      logic [31:0] count;

      always_ff @(posedge CLK or negedge RESET_N) begin
         if (!RESET_N)
            count <= '0;
         else if (STAT_CLR)
            count <= '0;
         else if (RX_SRC_RDY[j] && RX_DST_RDY[j] && count != '1)
            count <= count + 1'b1;
      end

      assign STAT_GRANTS[j*32 +: 32] = count;
   end
`endif

endmodule

// File: tb/tb_meta_arbiter.sv
// Self-checking bench for meta_arbiter: directed vector table, corner sequences, random vs. model.
module tb_meta_arbiter;

   localparam int NCH  = 4;
   localparam int MAXB = 4;

   logic       clk;
   logic       reset_n;
   logic [7:0] rx_data;
   logic [3:0] rx_src_rdy;
   logic [3:0] rx_dst_rdy;
   logic [1:0] tx_data;
   logic [1:0] tx_chan;
   logic       tx_src_rdy;
   logic       tx_dst_rdy;

   logic [3:0] b_rx_dst_rdy;
   logic [1:0] b_tx_data;
   logic [1:0] b_tx_chan;
   logic       b_tx_src_rdy;

   logic         stat_clr;
   logic [127:0] stat_grants;
   logic [127:0] b_stat_grants;

   int checks;
   int errors;

   meta_arbiter #(.CHANNELS(NCH), .META_WIDTH(2), .MAX_BURST(MAXB)) dut (
      .CLK        (clk),
      .RESET_N    (reset_n),
      .RX_DATA    (rx_data),
      .RX_SRC_RDY (rx_src_rdy),
      .RX_DST_RDY (rx_dst_rdy),
      .TX_DATA    (tx_data),
      .TX_CHAN    (tx_chan),
      .TX_SRC_RDY (tx_src_rdy),
      .TX_DST_RDY (tx_dst_rdy)
`ifdef META_ARBITER_STATS_EN
      ,
      .STAT_CLR   (stat_clr),
      .STAT_GRANTS(stat_grants)
`endif
   );

   meta_arbiter #(.CHANNELS(NCH), .META_WIDTH(2), .MAX_BURST(1)) dut_b1 (
      .CLK        (clk),
      .RESET_N    (reset_n),
      .RX_DATA    (rx_data),
      .RX_SRC_RDY (rx_src_rdy),
      .RX_DST_RDY (b_rx_dst_rdy),
      .TX_DATA    (b_tx_data),
      .TX_CHAN    (b_tx_chan),
      .TX_SRC_RDY (b_tx_src_rdy),
      .TX_DST_RDY (tx_dst_rdy)
`ifdef META_ARBITER_STATS_EN
      ,
      .STAT_CLR   (stat_clr),
      .STAT_GRANTS(b_stat_grants)
`endif
   );

`ifndef META_ARBITER_STATS_EN
   assign stat_grants   = '0;
   assign b_stat_grants = '0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: plain round-robin from the last grant, with the locked
   // channel jumping the queue while it still has burst budget.
   int m_lock;
   int m_last;
   int m_cnt;
   bit m_valid;
   int m_chan;
   int m_data;
   int counts[NCH];
   int transfers;

   function automatic int modelPick(input logic [3:0] req, input bit free);
      int c;
      if (!free) return -1;
      if (m_lock >= 0 && req[m_lock] && m_cnt < MAXB) return m_lock;
      for (int k = 1; k <= NCH; k++) begin
         c = (m_last + k) % NCH;
         if (req[c]) return c;
      end
      return -1;
   endfunction

   task automatic modelReset();
      m_lock = -1; m_last = NCH - 1; m_cnt = 0;
      m_valid = 1'b0; m_chan = 0; m_data = 0;
      transfers = 0;
      for (int i = 0; i < NCH; i++) counts[i] = 0;
   endtask

   task automatic modelStep(input int g, input bit free, input logic [7:0] data);
      if (!free) return;
      if (g >= 0) begin
         m_cnt   = (g == m_lock && m_cnt < MAXB) ? m_cnt + 1 : 1;
         m_lock  = g;
         m_last  = g;
         m_valid = 1'b1;
         m_chan  = g;
         m_data  = int'((data >> (2 * g)) & 8'h3);
         counts[g]++;
         transfers++;
      end else begin
         m_valid = 1'b0;
         m_lock  = -1;
         m_cnt   = 0;
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] req, input logic dst, input logic [7:0] data);
      @(negedge clk);
      rx_src_rdy = req;
      tx_dst_rdy = dst;
      rx_data    = data;
      #1;
   endtask

   task automatic doReset();
      @(negedge clk);
      reset_n    = 1'b0;
      rx_src_rdy = '0;
      tx_dst_rdy = 1'b1;
      stat_clr   = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   typedef struct {
      logic [3:0] req;
      logic       dst;
      logic [3:0] exp_rdy;
      logic       exp_valid;
      logic [1:0] exp_chan;
      logic [1:0] exp_data;
   } vec_t;

   vec_t vecs[15];

   localparam logic [7:0] TBL_DATA = 8'b00_01_10_11;

   initial begin
      int hs;
      int g;
      int cycles;
      int sum;
      bit free;
      logic [3:0] req;
      logic       dst;
      logic [7:0] data;
      logic [1:0] alt[5];

      checks = 0;
      errors = 0;
      reset_n = 1'b1;
      rx_src_rdy = '0;
      tx_dst_rdy = 1'b1;
      rx_data = '0;
      stat_clr = 1'b0;

      // All four request; channel 1's item stalls five cycles mid-run.
      vecs[0]  = '{4'hF, 1'b1, 4'b0001, 1'b0, 2'd0, 2'd0};
      vecs[1]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd3};
      vecs[2]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd3};
      vecs[3]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd3};
      vecs[4]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd0, 2'd3};
      for (int i = 5; i < 10; i++)
         vecs[i] = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 2'd2};
      vecs[10] = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd2};
      vecs[11] = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd2};
      vecs[12] = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd2};
      vecs[13] = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd1, 2'd2};
      vecs[14] = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd1};

      // Reset state, with requests present while reset is held.
      @(negedge clk);
      reset_n = 1'b0;
      rx_src_rdy = 4'hF;
      #1;
      checkOutput("reset_rx_dst_rdy", 32'(rx_dst_rdy), 32'h0);
      checkOutput("reset_tx_valid", 32'(tx_src_rdy), 32'h0);
      checkOutput("reset_tx_chan", 32'(tx_chan), 32'h0);
      checkOutput("reset_tx_data", 32'(tx_data), 32'h0);
      doReset();

      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].req, vecs[i].dst, TBL_DATA);
         checkOutput($sformatf("vec%0d_rx_dst_rdy", i), 32'(rx_dst_rdy), 32'(vecs[i].exp_rdy));
         checkOutput($sformatf("vec%0d_tx_valid", i), 32'(tx_src_rdy), 32'(vecs[i].exp_valid));
         checkOutput($sformatf("vec%0d_tx_chan", i), 32'(tx_chan), 32'(vecs[i].exp_chan));
         checkOutput($sformatf("vec%0d_tx_data", i), 32'(tx_data), 32'(vecs[i].exp_data));
      end

      // Single requester keeps streaming across burst boundaries.
      doReset();
      hs = 0;
      for (int i = 0; i <= 10; i++) begin
         applyStimulus((i < 10) ? 4'b0100 : 4'b0000, 1'b1, TBL_DATA);
         checkOutput($sformatf("solo%0d_rx_dst_rdy", i), 32'(rx_dst_rdy), (i < 10) ? 32'h4 : 32'h0);
         if (rx_dst_rdy[2]) hs++;
         if (i >= 1) begin
            checkOutput($sformatf("solo%0d_tx_valid", i), 32'(tx_src_rdy), 32'h1);
            checkOutput($sformatf("solo%0d_tx_chan", i), 32'(tx_chan), 32'h2);
         end
      end
      checkOutput("solo_handshakes", 32'(hs), 32'd10);

      // MAX_BURST=1 instance alternates between channels 1 and 3.
      doReset();
      alt[0] = 2'd0; alt[1] = 2'd1; alt[2] = 2'd3; alt[3] = 2'd1; alt[4] = 2'd3;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(4'b1010, 1'b1, TBL_DATA);
         if (i == 0) checkOutput("b1_first_rx_dst_rdy", 32'(b_rx_dst_rdy), 32'h2);
         if (i >= 1) begin
            checkOutput($sformatf("b1_%0d_tx_valid", i), 32'(b_tx_src_rdy), 32'h1);
            checkOutput($sformatf("b1_%0d_tx_chan", i), 32'(b_tx_chan), 32'(alt[i]));
         end
      end

      // Reset while an item is held drops it at once; priority restarts at 0.
      doReset();
      applyStimulus(4'hF, 1'b1, TBL_DATA);
      applyStimulus(4'hF, 1'b1, TBL_DATA);
      checkOutput("midreset_pre_valid", 32'(tx_src_rdy), 32'h1);
      checkOutput("midreset_pre_chan", 32'(tx_chan), 32'h0);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("midreset_tx_valid", 32'(tx_src_rdy), 32'h0);
      checkOutput("midreset_rx_dst_rdy", 32'(rx_dst_rdy), 32'h0);
      rx_src_rdy = '0;
      @(negedge clk);
      reset_n = 1'b1;
      applyStimulus(4'b1100, 1'b1, TBL_DATA);
      checkOutput("postreset_rx_dst_rdy", 32'(rx_dst_rdy), 32'h4);
      applyStimulus(4'b1100, 1'b1, TBL_DATA);
      checkOutput("postreset_tx_chan", 32'(tx_chan), 32'h2);

      // Random traffic and backpressure against the reference model.
      doReset();
      modelReset();
`ifdef META_ARBITER_STATS_EN
      applyStimulus(4'h0, 1'b1, 8'h0);
      for (int i = 0; i < NCH; i++)
         checkOutput($sformatf("stat%0d_after_reset", i), stat_grants[i*32 +: 32], 32'h0);
`endif
      cycles = 0;
      while (transfers < 2000 && cycles < 20000) begin
         req  = 4'($urandom_range(0, 15));
         dst  = ($urandom_range(0, 99) < 70);
         data = 8'($urandom);
         applyStimulus(req, dst, data);
         free = !m_valid || dst;
         g = modelPick(req, free);
         checkOutput("rnd_rx_dst_rdy", 32'(rx_dst_rdy), (g >= 0) ? (32'h1 << g) : 32'h0);
         checkOutput("rnd_tx_valid", 32'(tx_src_rdy), 32'(m_valid));
         if (m_valid) begin
            checkOutput("rnd_tx_chan", 32'(tx_chan), 32'(m_chan));
            checkOutput("rnd_tx_data", 32'(tx_data), 32'(m_data));
         end
         modelStep(g, free, data);
         cycles++;
      end
      checkOutput("rnd_transfers", 32'(transfers), 32'd2000);
      applyStimulus(4'h0, 1'b1, 8'h0);

`ifdef META_ARBITER_STATS_EN
      sum = 0;
      for (int i = 0; i < NCH; i++) begin
         sum += int'(stat_grants[i*32 +: 32]);
         checkOutput($sformatf("stat%0d_count", i), stat_grants[i*32 +: 32], 32'(counts[i]));
      end
      checkOutput("stat_sum", 32'(sum), 32'd2000);

      // Clear must win over a simultaneous increment.
      @(negedge clk);
      stat_clr   = 1'b1;
      rx_src_rdy = 4'hF;
      tx_dst_rdy = 1'b1;
      @(negedge clk);
      stat_clr   = 1'b0;
      rx_src_rdy = 4'h0;
      #1;
      for (int i = 0; i < NCH; i++)
         checkOutput($sformatf("stat%0d_cleared", i), stat_grants[i*32 +: 32], 32'h0);
`else
      sum = 0;
      for (int i = 0; i < NCH; i++) sum += counts[i];
      checkOutput("model_sum", 32'(sum), 32'd2000);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
